// File: rtl/bcd_sw_pkg.sv
// Shared types, constants and BCD helpers for the BCD stopwatch controller.
// Optional feature macro: BCD_STOPWATCH_AUTORELOAD_EN (see bcd_stopwatch_ctrl.sv).
package bcd_sw_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'b00,
        CMD_STOP  = 2'b01,
        CMD_CLEAR = 2'b10,
        CMD_LAP   = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } sw_state_e;

    localparam logic [15:0] BCD_MAX  = 16'h9999;
    localparam logic [15:0] BCD_ZERO = 16'h0000;

    // True when every nibble is a legal decimal digit.
    function automatic logic bcd_is_valid(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Four-digit BCD increment with ripple; 9999 rolls to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter datapath with per-digit carry enables.
// ena[i] is high when inc is high and all digits below i are 9.
module bcd_counter4
    import bcd_sw_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] q,
    output logic [3:1]  ena
);

    logic [3:0]  adv;
    logic [15:0] q_d;

    // Carry chain: a digit advances when every lower digit is about to roll over.
    always_comb begin
        ena[1] = inc    && (q[3:0]   == 4'd9);
        ena[2] = ena[1] && (q[7:4]   == 4'd9);
        ena[3] = ena[2] && (q[11:8]  == 4'd9);
        adv    = {ena, inc};
    end

    // Next count: clear has priority over increment.
    always_comb begin
        q_d = q;
        if (clr) begin
            q_d = BCD_ZERO;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (adv[i]) begin
                    q_d[4*i +: 4] = (q[4*i +: 4] == 4'd9) ? 4'd0 : q[4*i +: 4] + 4'd1;
                end
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= BCD_ZERO;
        end else begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// BCD stopwatch controller: command FSM, prescaler, limit register and lap slot.
// Define BCD_STOPWATCH_AUTORELOAD_EN to make a limit match reload 0000 and keep
// running (periodic timer) instead of stopping in DONE.
module bcd_stopwatch_ctrl
    import bcd_sw_pkg::*;
#(
    parameter int unsigned PRESCALE = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] limit,
    output logic [15:0] q,
    output logic [1:0]  state,
    output logic        tick,
    output logic        done,
    output logic        wrap,
    output logic [15:0] lap_q,
    output logic        lap_valid,
    input  logic        lap_ready
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    sw_state_e   state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0] limit_q, limit_d;
    cmd_op_e     op;
    logic        accept;
    logic        do_clear;
    logic        tick_now;
    logic        cnt_inc;
    logic        cnt_clr;
    logic        reload;
    logic        hit;
    logic        wrap_now;
    logic [15:0] q_next;
    logic [3:1]  cnt_ena;

    bcd_counter4 u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .q       (q),
        .ena     (cnt_ena)
    );

    // Handshake, tick generation and limit compare on the post-increment value.
    always_comb begin
        op        = cmd_op_e'(cmd_op);
        cmd_ready = !lap_valid || lap_ready;
        accept    = cmd_valid && cmd_ready;
        do_clear  = accept && (op == CMD_CLEAR);
        tick_now  = (state_q == ST_RUN) && (pre_q == PRE_LAST);
        // CLEAR beats a coincident tick.
        cnt_inc   = tick_now && !do_clear;
        q_next    = bcd_inc(q);
        // A non-BCD limit never matches, so the counter free-runs.
        hit       = cnt_inc && (limit_q != BCD_ZERO) && bcd_is_valid(limit_q)
                    && (q_next == limit_q);
        // ena[3] already implies the three lower digits are 9.
        wrap_now  = (&cnt_ena) && (q[15:12] == 4'd9);
        cnt_clr   = do_clear || reload;
    end

    // FSM next state, prescaler and limit latch.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        limit_d = limit_q;
        reload  = 1'b0;

        if (state_q == ST_RUN) begin
            pre_d = tick_now ? '0 : pre_q + PW'(1);
        end

        if (hit) begin
`ifdef BCD_STOPWATCH_AUTORELOAD_EN
            reload = 1'b1;
`else
            state_d = ST_DONE;
`endif
        end

        if (accept) begin
            unique case (op)
                CMD_START: begin
                    if (state_q == ST_IDLE) begin
                        state_d = ST_RUN;
                        pre_d   = '0;
                        limit_d = limit;
                    end else if (state_q == ST_PAUSE) begin
                        state_d = ST_RUN;
                    end
                end
                CMD_STOP: begin
                    // A limit match in the same cycle wins over STOP.
                    if (state_q == ST_RUN && state_d == ST_RUN) state_d = ST_PAUSE;
                end
                CMD_CLEAR: begin
                    state_d = ST_IDLE;
                    pre_d   = '0;
                end
                CMD_LAP: begin
                end
            endcase
        end
    end

    // Control registers and registered event pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            limit_q <= BCD_ZERO;
            tick    <= 1'b0;
            done    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            limit_q <= limit_d;
            tick    <= cnt_inc;
            done    <= hit;
            wrap    <= wrap_now;
        end
    end

    // Single-entry lap slot; a new LAP on the draining cycle keeps it full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lap_q     <= BCD_ZERO;
            lap_valid <= 1'b0;
        end else if (accept && op == CMD_LAP) begin
            lap_q     <= q;
            lap_valid <= 1'b1;
        end else if (lap_valid && lap_ready) begin
            lap_valid <= 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: doc/bcd_stopwatch_ctrl.md
Name: bcd_stopwatch_ctrl

Overview:
- Sequences a 4-digit BCD counter (0000–9999) as a stopwatch/timer.
- Accepts START/STOP/CLEAR/LAP commands over a valid/ready handshake.
- A prescaler turns clk into count ticks.
- The block stops at a programmable BCD limit and buffers one lap snapshot for a downstream consumer.
- Sits between the host command logic and display/compare logic.

Parameters:
- PRESCALE, 10, clk cycles per count tick; legal range ≥1; 1 means one tick every cycle in RUN.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  00 START, 01 STOP, 10 CLEAR, 11 LAP
- limit  in  16  BCD stop value; 0000 = free-run
- q  out  16  current BCD count (digit 0 = q[3:0])
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
- tick  out  1  1-cycle pulse: counter advanced this cycle
- done  out  1  1-cycle pulse on reaching limit
- wrap  out  1  1-cycle pulse on the 9999→0000 roll-over
- lap_q  out  16  captured count
- lap_valid  out  1  lap slot full
- lap_ready  in  1  consumer takes lap on lap_valid && lap_ready

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, q=0000, lap_q=0000.
  - lap_valid, tick, done, wrap = 0; prescaler = 0; limit register = 0000.
- Handshake:
  - cmd_ready = !lap_valid || lap_ready; a full, unconsumed lap slot stalls all commands.
  - lap_valid clears on handshake unless a new LAP is accepted in the same cycle; in that case it stays 1 with the new lap_q.
- Prescaler:
  - Increments only in RUN.
  - At PRESCALE-1 it returns to 0 and tick=1.
  - Held in PAUSE.
  - Zeroed on CLEAR and on START from IDLE.
- Counter:
  - On tick, BCD increment with digit ripple.
  - 9999 wraps to 0000 and asserts wrap.
  - Free-runs when limit_r==0000.
- Limit:
  - limit is latched into limit_r on START accepted in IDLE.
  - If limit_r != 0 and the post-increment value == limit_r: state→DONE and done=1 in the same cycle as the registered update.
  - Any non-BCD digit in limit_r never matches, so the counter free-runs.
- Commands, effective at the clock edge of acceptance:
  - START: IDLE→RUN; PAUSE→RUN (prescaler phase kept); ignored in RUN and DONE.
  - STOP: RUN→PAUSE; ignored otherwise.
  - CLEAR: any state→IDLE; q=0000, prescaler=0; lap slot untouched.
  - LAP: lap_q←q (pre-increment value of that cycle), lap_valid=1; legal in all states.
- Simultaneous events:
  - CLEAR beats tick.
  - STOP with tick: increment is applied, then PAUSE.
  - Limit match with STOP: DONE wins.
- Latency:
  - Commands take effect at the accepting edge; q, state and pulses are registered.
- Mid-operation reset_n assertion returns all state to the reset values immediately.

Optional Feature:
- Macro: BCD_STOPWATCH_AUTORELOAD_EN.
- Defined: on limit match, q←0000, done pulses, state stays RUN, and the prescaler phase continues (periodic timer).
- Undefined: limit match goes to DONE as above.
- Free-run behaviour (limit_r==0000) is identical in both builds.

Decomposition:
- Package bcd_sw_pkg holds:
  - cmd_op enum (CMD_START, CMD_STOP, CMD_CLEAR, CMD_LAP).
  - State enum (ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE).
  - BCD_MAX=16'h9999 and BCD_ZERO.
- Sub-module bcd_counter4 holds the datapath:
  - Inputs: clk, reset_n, clr, inc.
  - Outputs: q[15:0], plus per-digit carry-enable ena[3:1] (digit i advances when all lower digits are 9 and inc).
- The controller holds the FSM, prescaler, limit register and lap slot.

Test Plan:
- PRESCALE=4, limit=0000, START, run 40 clk → q=0010, tick every 4th cycle, state=RUN.
- limit=0025, START from IDLE, PRESCALE=1 → q reaches 0025, done pulses once, state=DONE, q frozen; START ignored; CLEAR → IDLE, q=0000.
- Preload run to q=0999 then one tick → q=1000, ena[3:1]=111 that cycle. At 9999 plus one tick → q=0000, wrap=1.
- LAP at q=0042 with lap_ready=0 → lap_q=0042, lap_valid=1, cmd_ready=0; STOP held is stalled until lap_ready=1, then accepted.
- STOP on tick cycle at q=0007 → q=0008, state=PAUSE. Later START resumes the prescaler phase with no extra tick. CLEAR with tick in the same cycle → q=0000.
- reset_n pulsed low mid-RUN, asynchronous to clk → all outputs return to reset values before the next edge. AUTORELOAD build with limit=0003 → q cycles 1,2,0 and done every 3rd tick.
